// File: rtl/grev_sched_pkg.sv
// Shared types and helpers for the grev_scheduler slice: tag layout,
// grant descriptor and the round-robin search used by the arbiter.
package grev_sched_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;
  localparam int MAX_REQ = 8;
  // Requester ids are sized for the largest supported NREQ so the types stay parameter-free.
  localparam int ID_W    = $clog2(MAX_REQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] idx;
  } grant_t;

  // First eligible requester at or after ptr, wrapping modulo nreq.
  function automatic grant_t rr_pick(input logic [MAX_REQ-1:0] elig,
                                     input logic [ID_W-1:0]    ptr,
                                     input int unsigned        nreq);
    logic [ID_W-1:0] cand;
    rr_pick = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      cand = ID_W'((32'(ptr) + k) % nreq);
      if (k < nreq && !rr_pick.found && elig[cand]) begin
        rr_pick.found = 1'b1;
        rr_pick.idx   = cand;
      end
    end
  endfunction

endpackage

// File: rtl/grev_resp_fifo.sv
// Per-requester response FIFO: synchronous, head word visible on rd_data,
// pops on an empty FIFO are ignored.
module grev_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_rd;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // NOTE: storage is deliberately not reset; count gates every read, so stale words are never observed.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= bump(wr_ptr);
      if (do_rd) rd_ptr <= bump(rd_ptr);
      if (wr_en && !do_rd)      count <= count + 1'b1;
      else if (do_rd && !wr_en) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) assert (!(wr_en && full));
  end

endmodule

// File: rtl/grev_scheduler.sv
// Shares one pipelined simplegrev unit among NREQ requesters: round-robin
// issue, fixed-latency owner tags, credit-guarded per-requester response FIFOs.
module grev_scheduler
  import grev_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int LAT     = 2,
  parameter int CREDITS = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*XLEN-1:0]    req_rs1,
  input  logic [NREQ*SHAMT_W-1:0] req_rs2,
  output logic [NREQ-1:0]         resp_valid,
  input  logic [NREQ-1:0]         resp_ready,
  output logic [NREQ*XLEN-1:0]    resp_rd,
  output logic [XLEN-1:0]         grev_rs1,
  output logic [SHAMT_W-1:0]      grev_rs2,
  input  logic [XLEN-1:0]         grev_rd
);

  localparam int CW = $clog2(CREDITS + 1);

  logic [CW-1:0]      credit [NREQ];
  logic [ID_W-1:0]    rr_ptr;
  logic [MAX_REQ-1:0] elig;
  grant_t             pick;
  logic               grant;
  tag_t               tag_q [LAT];
  logic [NREQ-1:0]    pop, fifo_wr, fifo_empty, fifo_full;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) elig[i] = req_valid[i] && (credit[i] != '0);
  end

  assign pick  = rr_pick(elig, rr_ptr, NREQ);
  assign grant = pick.found && !reset;

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    req_ready = '0;
    grev_rs1  = '0;
    grev_rs2  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant && pick.idx == ID_W'(i)) begin
        req_ready[i] = 1'b1;
        grev_rs1     = req_rs1[XLEN*i +: XLEN];
        grev_rs2     = req_rs2[SHAMT_W*i +: SHAMT_W];
      end
    end
  end

  // NOTE: state registers use <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      rr_ptr <= '0;
    else if (grant) rr_ptr <= (32'(pick.idx) == NREQ - 1) ? '0 : pick.idx + 1'b1;
  end

  // The tag pipeline mirrors simplegrev's latency and never stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= '{valid: grant, id: pick.idx};
      for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) credit[i] <= CW'(CREDITS);
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && !pop[i])      credit[i] <= credit[i] - 1'b1;
        else if (pop[i] && !req_ready[i]) credit[i] <= credit[i] + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign pop[i]        = resp_valid[i] && resp_ready[i];
    assign fifo_wr[i]    = tag_q[LAT-1].valid && (tag_q[LAT-1].id == ID_W'(i));
    assign resp_valid[i] = !fifo_empty[i];

    grev_resp_fifo #(.DEPTH(CREDITS), .WIDTH(XLEN)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (fifo_wr[i]),
      .wr_data (grev_rd),
      .rd_en   (pop[i]),
      .rd_data (resp_rd[XLEN*i +: XLEN]),
      .empty   (fifo_empty[i]),
      .full    (fifo_full[i])
    );

    always_ff @(posedge clock) begin
      if (!reset) begin
        assert (credit[i] <= CW'(CREDITS));
        assert (!(req_ready[i] && credit[i] == '0));
        assert (!(pop[i] && !req_ready[i] && credit[i] == CW'(CREDITS)));
        assert (!(fifo_wr[i] && fifo_full[i]));
      end
    end
  end

endmodule

// File: tb/tb_grev_scheduler.sv
// Directed bench for grev_scheduler: a 2-requester instance and a 4-requester
// instance, each driving its own pipelined simplegrev model with LAT=2.
module tb_grev_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [1:0]   a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
  logic [63:0]  a_req_rs1, a_resp_rd;
  logic [9:0]   a_req_rs2;
  logic [31:0]  a_grev_rs1, a_grev_rd, a_p1, a_p2;
  logic [4:0]   a_grev_rs2;

  logic [3:0]   b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
  logic [127:0] b_req_rs1, b_resp_rd;
  logic [19:0]  b_req_rs2;
  logic [31:0]  b_grev_rs1, b_grev_rd, b_p1, b_p2;
  logic [4:0]   b_grev_rs2;

  grev_scheduler #(.NREQ(2), .LAT(2), .CREDITS(2)) dut_a (
    .clock(clock), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_rs1(a_req_rs1), .req_rs2(a_req_rs2),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_rd(a_resp_rd),
    .grev_rs1(a_grev_rs1), .grev_rs2(a_grev_rs2), .grev_rd(a_grev_rd)
  );

  grev_scheduler #(.NREQ(4), .LAT(2), .CREDITS(2)) dut_b (
    .clock(clock), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_rs1(b_req_rs1), .req_rs2(b_req_rs2),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rd(b_resp_rd),
    .grev_rs1(b_grev_rs1), .grev_rs2(b_grev_rs2), .grev_rd(b_grev_rd)
  );

  function automatic logic [31:0] grev32(input logic [31:0] x, input logic [4:0] k);
    logic [31:0] r;
    r = x;
    if (k[0]) r = ((r & 32'h55555555) << 1)  | ((r >> 1)  & 32'h55555555);
    if (k[1]) r = ((r & 32'h33333333) << 2)  | ((r >> 2)  & 32'h33333333);
    if (k[2]) r = ((r & 32'h0f0f0f0f) << 4)  | ((r >> 4)  & 32'h0f0f0f0f);
    if (k[3]) r = ((r & 32'h00ff00ff) << 8)  | ((r >> 8)  & 32'h00ff00ff);
    if (k[4]) r = ((r & 32'h0000ffff) << 16) | ((r >> 16) & 32'h0000ffff);
    return r;
  endfunction

  // Shared simplegrev units: result of operands in cycle t is on grev_rd in cycle t+2.
  always @(posedge clock) begin
    a_p1 <= grev32(a_grev_rs1, a_grev_rs2);
    a_p2 <= a_p1;
    b_p1 <= grev32(b_grev_rs1, b_grev_rs2);
    b_p2 <= b_p1;
  end
  assign a_grev_rd = a_p2;
  assign b_grev_rd = b_p2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [1:0] rr_ready_exp [8] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] rr_resp_exp  [8] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_req_valid = 2'b11; a_req_rs1 = '0; a_req_rs2 = '0; a_resp_ready = '0;
    b_req_valid = '0;    b_req_rs1 = '0; b_req_rs2 = '0; b_resp_ready = '0;

    // Reset values, with requests pending while reset is held
    #2;
    check("rst_req_ready",  32'(a_req_ready),  32'h0);
    check("rst_resp_valid", 32'(a_resp_valid), 32'h0);
    check("rst_resp_rd0",   a_resp_rd[31:0],   32'h0);
    check("rst_resp_rd1",   a_resp_rd[63:32],  32'h0);
    check("rst_grev_rs1",   a_grev_rs1,        32'h0);
    check("rst_grev_rs2",   32'(a_grev_rs2),   32'h0);
    check("rst_b_ready",    32'(b_req_ready),  32'h0);
    tick();
    reset = 1'b0;
    a_req_valid = 2'b00;

    // Single op: full bit reverse on requester 0
    a_req_valid = 2'b01; a_req_rs1[31:0] = 32'h12345678; a_req_rs2[4:0] = 5'h1f;
    #1;
    check("single_ready",    32'(a_req_ready), 32'h1);
    check("single_grev_rs1", a_grev_rs1,       32'h12345678);
    check("single_grev_rs2", 32'(a_grev_rs2),  32'h1f);
    tick();
    a_req_valid = 2'b00;
    #1;
    check("idle_grev_rs1",  a_grev_rs1,         32'h0);
    check("single_rv_t1",   32'(a_resp_valid),  32'h0);
    tick(); #1;
    check("single_rv_t2",   32'(a_resp_valid),  32'h0);
    tick(); #1;
    check("single_rv_t3",   32'(a_resp_valid),  32'h1);
    check("single_rd",      a_resp_rd[31:0],    32'h1E6A2C48);
    a_resp_ready = 2'b01;
    tick(); #1;
    check("single_popped",  32'(a_resp_valid),  32'h0);
    a_resp_ready = 2'b00;

    // Round-robin between two continuously valid requesters
    do_reset();
    a_req_rs1 = {2{32'h12345678}};
    a_req_rs2 = {5'h10, 5'h18};
    a_resp_ready = 2'b11;
    for (int c = 0; c < 8; c++) begin
      a_req_valid = (c < 4) ? 2'b11 : 2'b00;
      #1;
      check($sformatf("rr_ready[%0d]", c), 32'(a_req_ready),  32'(rr_ready_exp[c]));
      check($sformatf("rr_rv[%0d]", c),    32'(a_resp_valid), 32'(rr_resp_exp[c]));
      if (c == 3 || c == 5) check($sformatf("rr_rd0[%0d]", c), a_resp_rd[31:0],  32'h78563412);
      if (c == 4 || c == 6) check($sformatf("rr_rd1[%0d]", c), a_resp_rd[63:32], 32'h56781234);
      tick();
    end
    a_resp_ready = 2'b00;

    // Credit stall on requester 0 with its consumer blocked
    do_reset();
    a_req_rs1 = {2{32'h12345678}};
    a_req_rs2 = '0;
    a_req_valid = 2'b01;
    #1; check("cs_ready_c0", 32'(a_req_ready), 32'h1);
    tick();
    a_req_rs2[4:0] = 5'h08;
    #1; check("cs_ready_c1", 32'(a_req_ready), 32'h1);
    tick();
    a_req_rs2[4:0] = 5'h1f;
    #1; check("cs_ready_c2", 32'(a_req_ready), 32'h0);
    tick(); #1;
    check("cs_ready_c3", 32'(a_req_ready),  32'h0);
    check("cs_rv_c3",    32'(a_resp_valid), 32'h1);
    check("cs_rd_c3",    a_resp_rd[31:0],   32'h12345678);
    tick(); #1; check("cs_ready_c4", 32'(a_req_ready), 32'h0);
    tick(); #1; check("cs_ready_c5", 32'(a_req_ready), 32'h0);
    tick();
    a_resp_ready = 2'b01;
    #1;
    check("cs_pop_cycle_ready", 32'(a_req_ready), 32'h0);
    check("cs_rd_c6",           a_resp_rd[31:0],  32'h12345678);
    tick();
    a_resp_ready = 2'b00;
    #1;
    check("cs_regrant",    32'(a_req_ready), 32'h1);
    check("cs_regrant_rs2", 32'(a_grev_rs2), 32'h1f);
    check("cs_rd_c7",      a_resp_rd[31:0],  32'h34127856);
    tick(); #1;
    check("cs_one_more_only", 32'(a_req_ready), 32'h0);
    tick();
    a_req_valid = 2'b00;
    #1; check("cs_rd_c9", a_resp_rd[31:0], 32'h34127856);
    tick();
    a_resp_ready = 2'b01;
    #1; check("cs_second", a_resp_rd[31:0], 32'h34127856);
    tick(); #1;
    check("cs_third_rv", 32'(a_resp_valid), 32'h1);
    check("cs_third",    a_resp_rd[31:0],   32'h1E6A2C48);
    tick(); #1;
    check("cs_drained", 32'(a_resp_valid), 32'h0);
    a_resp_ready = 2'b00;
    // Credits back at exactly two: two grants then stall
    a_req_valid = 2'b01; a_req_rs2 = '0;
    #1; check("cs_full_g1", 32'(a_req_ready), 32'h1);
    tick(); #1; check("cs_full_g2", 32'(a_req_ready), 32'h1);
    tick(); #1; check("cs_full_g3", 32'(a_req_ready), 32'h0);
    a_req_valid = 2'b00;
    a_resp_ready = 2'b01;
    repeat (4) tick();
    a_resp_ready = 2'b00;

    // Reset one cycle after two grants
    do_reset();
    a_req_rs1 = {2{32'h12345678}};
    a_req_rs2 = {5'h18, 5'h1f};
    a_req_valid = 2'b11;
    #1; check("rm_grant0", 32'(a_req_ready), 32'h1);
    tick(); #1; check("rm_grant1", 32'(a_req_ready), 32'h2);
    tick();
    a_req_valid = 2'b00;
    reset = 1'b1;
    #1;
    check("rm_rv_in_reset",    32'(a_resp_valid), 32'h0);
    check("rm_ready_in_reset", 32'(a_req_ready),  32'h0);
    tick();
    reset = 1'b0;
    for (int c = 3; c < 6; c++) begin
      #1; check($sformatf("rm_rv_after[%0d]", c), 32'(a_resp_valid), 32'h0);
      tick();
    end
    a_req_valid = 2'b01; a_req_rs2[4:0] = 5'h18;
    #1; check("rm_post_g1", 32'(a_req_ready), 32'h1);
    tick();
    a_req_rs2[4:0] = 5'h10;
    #1; check("rm_post_g2", 32'(a_req_ready), 32'h1);
    tick(); #1; check("rm_post_g3", 32'(a_req_ready), 32'h0);
    tick();
    a_req_valid = 2'b00;
    a_resp_ready = 2'b01;
    #1;
    check("rm_post_rv1", 32'(a_resp_valid), 32'h1);
    check("rm_post_rd1", a_resp_rd[31:0],   32'h78563412);
    tick(); #1;
    check("rm_post_rv2", 32'(a_resp_valid), 32'h1);
    check("rm_post_rd2", a_resp_rd[31:0],   32'h56781234);
    tick(); #1;
    check("rm_post_empty", 32'(a_resp_valid), 32'h0);
    a_resp_ready = 2'b00;

    // Fairness with four requesters
    do_reset();
    b_req_rs1 = {4{32'h12345678}};
    b_req_rs2 = {5'h00, 5'h10, 5'h18, 5'h1f};
    b_resp_ready = 4'b1111;
    for (int c = 0; c < 11; c++) begin
      b_req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      check($sformatf("fair_ready[%0d]", c), 32'(b_req_ready),
            (c < 8) ? (32'h1 << (c % 4)) : 32'h0);
      check($sformatf("fair_rv[%0d]", c), 32'(b_resp_valid),
            (c >= 3) ? (32'h1 << ((c - 3) % 4)) : 32'h0);
      if (c == 3) check("fair_rd0", b_resp_rd[31:0],   32'h1E6A2C48);
      if (c == 4) check("fair_rd1", b_resp_rd[63:32],  32'h78563412);
      if (c == 5) check("fair_rd2", b_resp_rd[95:64],  32'h56781234);
      if (c == 6) check("fair_rd3", b_resp_rd[127:96], 32'h12345678);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
